string_voice_sched: RTL and testbench

//  Single-voice scheduler for the photonic harp: watches the 8 laser-beam strings, debounces them and

---
 rtl/string_voice_sched.sv | 203 ++++++++++++++++++++
 tb/tb_string_voice_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/string_voice_sched.sv
// string_voice_sched: debounces NUM_STR beam strings and gives one square-wave voice to the last-pressed string.
// Latency: beam_n edge -> held edge 2+DEB_CYC cycles; held edge -> voice takeover 1 further cycle.
// Backpressure: none, free-running tone. Release tail is built only with STRING_SCHED_RELEASE_EN defined.
module string_voice_sched #(
   parameter  int NUM_STR     = 8,
   parameter  int HDC_W       = 20,
   parameter  int DEB_CYC     = 500000,
   parameter  int RELEASE_CYC = 5000000,
   localparam int IDX_W       = (NUM_STR > 1) ? $clog2(NUM_STR) : 1
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [NUM_STR-1:0]       beam_n,
   input  logic [NUM_STR*HDC_W-1:0] hdc_bus,
   output logic                     note_valid,
   output logic [IDX_W-1:0]         note_idx,
   output logic [HDC_W-1:0]         hdc_sel,
   output logic                     audio_out,
   output logic [NUM_STR-1:0]       held
);

   localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

`ifdef STRING_SCHED_RELEASE_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_REL  = 2'd2
   } state_t;
   localparam int TAIL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
   localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(RELEASE_CYC - 1);
   logic [TAIL_W-1:0] tail_cnt;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1
   } state_t;
   // Tail length has no meaning without the release tail.
   logic unused_release_cyc;
   assign unused_release_cyc = (RELEASE_CYC != 0);
`endif

   state_t             state, state_nx;
   logic [NUM_STR-1:0] brk_s1, brk_s2;   // synchronised "beam broken" levels
   logic [NUM_STR-1:0] held_q;
   logic [DEB_W-1:0]   deb_cnt [NUM_STR];
   logic [NUM_STR-1:0] press, rel;
   logic [HDC_W-1:0]   hdc_arr [NUM_STR];
   logic [HDC_W-1:0]   tone_cnt;
   logic               take;
   logic [IDX_W-1:0]   take_idx;
   logic               owner_rel;

   // Highest set index of a string vector; 0 when empty.
   function automatic logic [IDX_W-1:0] hi_idx(input logic [NUM_STR-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_STR; i++) begin
         if (v[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Unpack the half-duty-cycle bus into per-string entries.
   always_comb begin
      for (int i = 0; i < NUM_STR; i++) begin
         hdc_arr[i] = hdc_bus[i*HDC_W +: HDC_W];
      end
   end

   // Two-flop synchroniser; the inversion makes a cleared flop mean "beam intact".
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         brk_s1 <= '0;
         brk_s2 <= '0;
      end else begin
         brk_s1 <= ~beam_n;
         brk_s2 <= brk_s1;
      end
   end

   // Per-string debounce: accept a new level after DEB_CYC consecutive mismatching cycles.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         held <= '0;
         for (int i = 0; i < NUM_STR; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_STR; i++) begin
            if (brk_s2[i] == held[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i] <= '0;
               held[i]    <= brk_s2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Previous held vector, for edge detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) held_q <= '0;
      else         held_q <= held;
   end

   assign press     = held & ~held_q;
   assign rel       = held_q & ~held;
   assign owner_rel = rel[note_idx];

   // FSM state register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nx;
   end

   // Next state and voice takeover decision; a press always beats a simultaneous release.
   always_comb begin
      state_nx = state;
      take     = 1'b0;
      take_idx = note_idx;
      case (state)
         ST_IDLE: begin
            if (|press) begin
               state_nx = ST_PLAY;
               take     = 1'b1;
               take_idx = hi_idx(press);
            end
         end
         ST_PLAY: begin
            if (|press) begin
               take     = 1'b1;
               take_idx = hi_idx(press);
            end else if (owner_rel) begin
               if (|held) begin
                  take     = 1'b1;
                  take_idx = hi_idx(held);
               end else begin
`ifdef STRING_SCHED_RELEASE_EN
                  state_nx = ST_REL;
`else
                  state_nx = ST_IDLE;
`endif
               end
            end
         end
`ifdef STRING_SCHED_RELEASE_EN
         ST_REL: begin
            if (|press) begin
               state_nx = ST_PLAY;
               take     = 1'b1;
               take_idx = hi_idx(press);
            end else if (tail_cnt == TAIL_LAST) begin
               state_nx = ST_IDLE;
            end
         end
`endif
         default: state_nx = ST_IDLE;
      endcase
   end

`ifdef STRING_SCHED_RELEASE_EN
   // Tail counter runs only while staying in RELEASE; zero on entry.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                                  tail_cnt <= '0;
      else if (state == ST_REL && state_nx == ST_REL) tail_cnt <= tail_cnt + 1'b1;
      else                                          tail_cnt <= '0;
   end
`endif

   // Tone generator: restart on takeover, reload pitch only at half-period boundaries.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         note_idx  <= '0;
         hdc_sel   <= '0;
         tone_cnt  <= '0;
         audio_out <= 1'b0;
      end else if (take) begin
         note_idx  <= take_idx;
         hdc_sel   <= hdc_arr[take_idx];
         tone_cnt  <= '0;
         audio_out <= 1'b0;
      end else if (state_nx == ST_IDLE) begin
         tone_cnt  <= '0;
         audio_out <= 1'b0;
      end else if (hdc_sel < HDC_W'(2)) begin
         // No usable period: stay silent; no boundary exists, so track the bus directly.
         tone_cnt  <= '0;
         audio_out <= 1'b0;
         hdc_sel   <= hdc_arr[note_idx];
      end else if (tone_cnt == hdc_sel - 1'b1) begin
         tone_cnt  <= '0;
         audio_out <= ~audio_out;
         hdc_sel   <= hdc_arr[note_idx];
      end else begin
         tone_cnt  <= tone_cnt + 1'b1;
      end
   end

   assign note_valid = (state != ST_IDLE);

endmodule

// File: tb/tb_string_voice_sched.sv
// tb_string_voice_sched: directed checks of debounce, arbitration, pitch reload, release and reset.
// Timing: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Release-tail expectations follow STRING_SCHED_RELEASE_EN.
module tb_string_voice_sched;
   localparam int NS = 8;
   localparam int HW = 20;

   logic              clock  = 1'b0;
   logic              resetn = 1'b0;
   logic [NS-1:0]     beam_n = '1;
   logic [NS*HW-1:0]  hdc_bus = '0;
   logic              note_valid;
   logic [2:0]        note_idx;
   logic [HW-1:0]     hdc_sel;
   logic              audio_out;
   logic [NS-1:0]     held;
   int checks = 0;
   int errors = 0;

   string_voice_sched #(.NUM_STR(NS), .HDC_W(HW), .DEB_CYC(4), .RELEASE_CYC(10)) dut (
      .clock(clock), .resetn(resetn), .beam_n(beam_n), .hdc_bus(hdc_bus),
      .note_valid(note_valid), .note_idx(note_idx), .hdc_sel(hdc_sel),
      .audio_out(audio_out), .held(held)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_hdc(input int i, input int v);
      hdc_bus[i*HW +: HW] = HW'(v);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      beam_n = '1;
      for (int i = 0; i < NS; i++) set_hdc(i, 4 + i);
      cyc(3);
      checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", note_valid); end
      checks++; if (note_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got %0d want 0", note_idx); end
      checks++; if (hdc_sel !== 20'd0) begin errors++; $display("FAIL rst_hdc got %0d want 0", hdc_sel); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL rst_audio got %0b want 0", audio_out); end
      checks++; if (held !== 8'h00) begin errors++; $display("FAIL rst_held got %h want 00", held); end
      resetn = 1'b1;
      cyc(10);
      checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_idle got %0b want 0", note_valid); end
   endtask

   task automatic test_debounce;
      int bad;
      beam_n[2] = 1'b0;
      cyc(3);
      beam_n[2] = 1'b1;
      bad = 0;
      repeat (12) begin
         cyc(1);
         if (held !== 8'h00 || note_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL deb_glitch bad cycles %0d want 0", bad); end
      beam_n[2] = 1'b0;
      cyc(5);
      checks++; if (held !== 8'h00) begin errors++; $display("FAIL deb_early got %h want 00", held); end
      cyc(1);
      checks++; if (held !== 8'h04) begin errors++; $display("FAIL deb_held got %h want 04", held); end
      checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL deb_evt_lat got %0b want 0", note_valid); end
      cyc(1);
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL deb_valid got %0b want 1", note_valid); end
      checks++; if (note_idx !== 3'd2) begin errors++; $display("FAIL deb_idx got %0d want 2", note_idx); end
      checks++; if (hdc_sel !== 20'd6) begin errors++; $display("FAIL deb_hdc got %0d want 6", hdc_sel); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL deb_audio0 got %0b want 0", audio_out); end
      cyc(3);
      beam_n[2] = 1'b1;
      cyc(2);
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL deb_pre_tgl got %0b want 0", audio_out); end
      cyc(1);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL deb_tgl got %0b want 1", audio_out); end
      cyc(4);
`ifdef STRING_SCHED_RELEASE_EN
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL deb_tail_valid got %0b want 1", note_valid); end
      cyc(8);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL deb_tail_tone got %0b want 1", audio_out); end
      cyc(2);
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0) begin errors++; $display("FAIL deb_tail_end got %0b/%0b want 0/0", note_valid, audio_out); end
`else
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0) begin errors++; $display("FAIL deb_off got %0b/%0b want 0/0", note_valid, audio_out); end
      checks++; if (hdc_sel !== 20'd6 || note_idx !== 3'd2) begin errors++; $display("FAIL deb_idle_hold got %0d/%0d want 6/2", hdc_sel, note_idx); end
`endif
      cyc(5);
   endtask

   task automatic test_priority;
      beam_n[1] = 1'b0;
      beam_n[5] = 1'b0;
      cyc(7);
      checks++; if (held !== 8'h22) begin errors++; $display("FAIL pri_held got %h want 22", held); end
      checks++; if (note_idx !== 3'd5 || hdc_sel !== 20'd9) begin errors++; $display("FAIL pri_same_cyc got %0d/%0d want 5/9", note_idx, hdc_sel); end
      beam_n[3] = 1'b0;
      cyc(7);
      checks++; if (note_idx !== 3'd3 || hdc_sel !== 20'd7) begin errors++; $display("FAIL pri_last got %0d/%0d want 3/7", note_idx, hdc_sel); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL pri_take_audio got %0b want 0", audio_out); end
      beam_n[3] = 1'b1;
      cyc(6);
      checks++; if (note_idx !== 3'd3) begin errors++; $display("FAIL pri_rel_early got %0d want 3", note_idx); end
      cyc(1);
      checks++; if (note_idx !== 3'd5 || hdc_sel !== 20'd9 || note_valid !== 1'b1) begin errors++; $display("FAIL pri_fallback got %0d/%0d/%0b want 5/9/1", note_idx, hdc_sel, note_valid); end
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL pri_fallback_audio got %0b want 0", audio_out); end
   endtask

   // Continues from the previous task: string 5 just took the voice with a 9-cycle half period.
   task automatic test_glitch_free;
      cyc(1);
      beam_n[1] = 1'b1;
      cyc(2);
      set_hdc(5, 12);
      cyc(5);
      checks++; if (audio_out !== 1'b0 || hdc_sel !== 20'd9) begin errors++; $display("FAIL gf_hold got %0b/%0d want 0/9", audio_out, hdc_sel); end
      cyc(1);
      checks++; if (audio_out !== 1'b1 || hdc_sel !== 20'd12) begin errors++; $display("FAIL gf_reload got %0b/%0d want 1/12", audio_out, hdc_sel); end
      cyc(1);
      checks++; if (note_idx !== 3'd5 || note_valid !== 1'b1 || held !== 8'h20) begin errors++; $display("FAIL gf_nonowner got %0d/%0b/%h want 5/1/20", note_idx, note_valid, held); end
      cyc(10);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL gf_pre_tgl got %0b want 1", audio_out); end
      cyc(1);
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL gf_tgl12 got %0b want 0", audio_out); end
      set_hdc(5, 9);
   endtask

   task automatic test_release;
      beam_n[5] = 1'b1;
      cyc(3);
      beam_n[6] = 1'b0;
      cyc(4);
`ifdef STRING_SCHED_RELEASE_EN
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL rel_tail got %0b want 1", note_valid); end
`else
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0) begin errors++; $display("FAIL rel_off got %0b/%0b want 0/0", note_valid, audio_out); end
`endif
      cyc(3);
      checks++; if (note_valid !== 1'b1 || note_idx !== 3'd6 || hdc_sel !== 20'd10 || audio_out !== 1'b0) begin errors++; $display("FAIL rel_repress got %0b/%0d/%0d/%0b want 1/6/10/0", note_valid, note_idx, hdc_sel, audio_out); end
      cyc(9);
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL rel_pre_tgl got %0b want 0", audio_out); end
      cyc(1);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL rel_tgl got %0b want 1", audio_out); end
      beam_n[6] = 1'b1;
      cyc(7);
`ifdef STRING_SCHED_RELEASE_EN
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL tail_start got %0b want 1", note_valid); end
      cyc(2);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL tail_tone_a got %0b want 1", audio_out); end
      cyc(1);
      checks++; if (audio_out !== 1'b0) begin errors++; $display("FAIL tail_tone_b got %0b want 0", audio_out); end
      cyc(6);
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL tail_last got %0b want 1", note_valid); end
      cyc(1);
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0) begin errors++; $display("FAIL tail_end got %0b/%0b want 0/0", note_valid, audio_out); end
`else
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0) begin errors++; $display("FAIL rel_off2 got %0b/%0b want 0/0", note_valid, audio_out); end
`endif
      cyc(5);
   endtask

   task automatic test_back_to_back;
      beam_n[4] = 1'b0;
      cyc(7);
      checks++; if (note_idx !== 3'd4) begin errors++; $display("FAIL b2b_first got %0d want 4", note_idx); end
      beam_n[6] = 1'b0;
      cyc(7);
      checks++; if (note_idx !== 3'd6) begin errors++; $display("FAIL b2b_second got %0d want 6", note_idx); end
      beam_n[6] = 1'b1;
      beam_n[2] = 1'b0;
      cyc(6);
      checks++; if (held !== 8'h14) begin errors++; $display("FAIL b2b_held got %h want 14", held); end
      cyc(1);
      checks++; if (note_idx !== 3'd2 || hdc_sel !== 20'd6 || note_valid !== 1'b1) begin errors++; $display("FAIL b2b_press_wins got %0d/%0d/%0b want 2/6/1", note_idx, hdc_sel, note_valid); end
      beam_n[2] = 1'b1;
      beam_n[4] = 1'b1;
      cyc(7);
`ifdef STRING_SCHED_RELEASE_EN
      checks++; if (note_valid !== 1'b1) begin errors++; $display("FAIL b2b_tail got %0b want 1", note_valid); end
`else
      checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", note_valid); end
`endif
      cyc(15);
   endtask

   task automatic test_degenerate;
      int bad;
      set_hdc(0, 0);
      beam_n[0] = 1'b0;
      cyc(7);
      checks++; if (note_valid !== 1'b1 || note_idx !== 3'd0 || hdc_sel !== 20'd0) begin errors++; $display("FAIL deg_take got %0b/%0d/%0d want 1/0/0", note_valid, note_idx, hdc_sel); end
      bad = 0;
      repeat (20) begin
         cyc(1);
         if (audio_out !== 1'b0 || note_valid !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL deg_silent bad cycles %0d want 0", bad); end
      beam_n[0] = 1'b1;
      set_hdc(0, 4);
      cyc(25);
   endtask

   task automatic test_reset_mid;
      beam_n[7] = 1'b0;
      cyc(7);
      checks++; if (note_idx !== 3'd7 || hdc_sel !== 20'd11) begin errors++; $display("FAIL rm_take got %0d/%0d want 7/11", note_idx, hdc_sel); end
      cyc(11);
      checks++; if (audio_out !== 1'b1) begin errors++; $display("FAIL rm_tone got %0b want 1", audio_out); end
      resetn = 1'b0;
      beam_n = '1;
      #1;
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0 || held !== 8'h00) begin errors++; $display("FAIL rm_async got %0b/%0b/%h want 0/0/00", note_valid, audio_out, held); end
      checks++; if (note_idx !== 3'd0 || hdc_sel !== 20'd0) begin errors++; $display("FAIL rm_voice got %0d/%0d want 0/0", note_idx, hdc_sel); end
      cyc(2);
      resetn = 1'b1;
      cyc(15);
      checks++; if (note_valid !== 1'b0 || audio_out !== 1'b0 || held !== 8'h00) begin errors++; $display("FAIL rm_no_tail got %0b/%0b/%h want 0/0/00", note_valid, audio_out, held); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_priority();
      test_glitch_free();
      test_release();
      test_back_to_back();
      test_degenerate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
